// File: rtl/md4_round3_iter.sv
// rtl/md4_round3_iter.sv - iterative MD4 round-3 engine, one step per clock, with chaining feed-forward
module md4_round3_iter #(
    parameter logic [31:0] K3           = 32'h6ED9EBA1,
    parameter bit          FEED_FORWARD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [511:0] x,
    input  logic [31:0]  ha,
    input  logic [31:0]  hb,
    input  logic [31:0]  hc,
    input  logic [31:0]  hd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_a,
    output logic [31:0]  out_b,
    output logic [31:0]  out_c,
    output logic [31:0]  out_d
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_step;
    logic [31:0]    r_a, r_b, r_c, r_d;
    logic [511:0]   r_x;
    logic [31:0]    r_ha, r_hb, r_hc, r_hd;
    logic [31:0]    r_out_a, r_out_b, r_out_c, r_out_d;
    logic           r_out_valid;

    logic [3:0]     w_k;
    logic [31:0]    w_xk, w_base, w_mix, w_sum, w_rot;
    logic [31:0]    w_na, w_nb, w_nc, w_nd;
    logic [31:0]    w_fa, w_fb, w_fc, w_fd;

    // Round-3 word order is the bit-reversal of the step index
    assign w_k  = {r_step[0], r_step[1], r_step[2], r_step[3]};
    assign w_xk = r_x[{w_k, 5'd0} +: 32];

    always_comb begin
        w_base = r_a;
        w_mix  = r_b ^ r_c ^ r_d;
        case (r_step[1:0])
            2'd1:    begin w_base = r_d; w_mix = r_a ^ r_b ^ r_c; end
            2'd2:    begin w_base = r_c; w_mix = r_d ^ r_a ^ r_b; end
            2'd3:    begin w_base = r_b; w_mix = r_c ^ r_d ^ r_a; end
            default: ;
        endcase
        w_sum = w_base + w_mix + w_xk + K3;
        case (r_step[1:0])
            2'd0:    w_rot = {w_sum[28:0], w_sum[31:29]};
            2'd1:    w_rot = {w_sum[22:0], w_sum[31:23]};
            2'd2:    w_rot = {w_sum[20:0], w_sum[31:21]};
            default: w_rot = {w_sum[16:0], w_sum[31:17]};
        endcase
        w_na = r_a;
        w_nb = r_b;
        w_nc = r_c;
        w_nd = r_d;
        case (r_step[1:0])
            2'd0:    w_na = w_rot;
            2'd1:    w_nd = w_rot;
            2'd2:    w_nc = w_rot;
            default: w_nb = w_rot;
        endcase
        w_fa = FEED_FORWARD ? w_na + r_ha : w_na;
        w_fb = FEED_FORWARD ? w_nb + r_hb : w_nb;
        w_fc = FEED_FORWARD ? w_nc + r_hc : w_nc;
        w_fd = FEED_FORWARD ? w_nd + r_hd : w_nd;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (r_step == 4'd15) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= 4'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_x         <= '0;
            r_ha        <= '0;
            r_hb        <= '0;
            r_hc        <= '0;
            r_hd        <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
            r_out_d     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_c    <= c;
                        r_d    <= d;
                        r_x    <= x;
                        r_ha   <= ha;
                        r_hb   <= hb;
                        r_hc   <= hc;
                        r_hd   <= hd;
                        r_step <= 4'd0;
                    end
                end
                S_RUN: begin
                    r_a <= w_na;
                    r_b <= w_nb;
                    r_c <= w_nc;
                    r_d <= w_nd;
                    if (r_step == 4'd15) begin
                        r_out_a     <= w_fa;
                        r_out_b     <= w_fb;
                        r_out_c     <= w_fc;
                        r_out_d     <= w_fd;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_c     = r_out_c;
    assign out_d     = r_out_d;

endmodule

// File: tb/tb_md4_round3_iter.sv
// tb/tb_md4_round3_iter.sv - self-checking bench for md4_round3_iter with a full MD4 reference model
module tb_md4_round3_iter;

    typedef logic [3:0][31:0] st_t;
    typedef struct {
        logic [511:0] x;
        st_t          h;
        st_t          exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  a, b, c, d, ha, hb, hc, hd;
    logic [511:0] x;
    logic [31:0]  out_a, out_b, out_c, out_d;

    logic         z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [31:0]  z_a, z_b, z_c, z_d, z_ha, z_hb, z_hc, z_hd;
    logic [511:0] z_x;
    logic [31:0]  z_out_a, z_out_b, z_out_c, z_out_d;

    int   n_vec = 0;
    int   n_bad = 0;
    st_t  exp_q[$];
    vec_t vecs[6];
    int   k3_order[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;

    md4_round3_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .x(x), .ha(ha), .hb(hb), .hc(hc), .hd(hd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
    );

    md4_round3_iter #(.FEED_FORWARD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .a(z_a), .b(z_b), .c(z_c), .d(z_d), .x(z_x), .ha(z_ha), .hb(z_hb), .hc(z_hc), .hd(z_hd),
        .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_a(z_out_a), .out_b(z_out_b), .out_c(z_out_c), .out_d(z_out_d)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int sh);
        return (v << sh) | (v >> (32 - sh));
    endfunction

    function automatic logic [127:0] pack(input st_t s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    // s[0..3] = A,B,C,D; the target register rotates A,D,C,B and its three operands follow cyclically
    function automatic st_t md4_step(input st_t s, input int rnd, input int i, input logic [511:0] m);
        st_t r;
        int t, k, sh;
        logic [31:0] p, q, u, f, cst;
        r = s;
        t = (4 - (i % 4)) % 4;
        p = s[(t + 1) % 4];
        q = s[(t + 2) % 4];
        u = s[(t + 3) % 4];
        if (rnd == 1) begin
            f = (p & q) | (~p & u); k = i; cst = 32'h0;
            case (i % 4) 0: sh = 3; 1: sh = 7; 2: sh = 11; default: sh = 19; endcase
        end else if (rnd == 2) begin
            f = (p & q) | (p & u) | (q & u); k = (i % 4) * 4 + i / 4; cst = 32'h5A827999;
            case (i % 4) 0: sh = 3; 1: sh = 5; 2: sh = 9; default: sh = 13; endcase
        end else begin
            f = p ^ q ^ u; k = k3_order[i]; cst = 32'h6ED9EBA1;
            case (i % 4) 0: sh = 3; 1: sh = 9; 2: sh = 11; default: sh = 15; endcase
        end
        r[t] = rotl(s[t] + f + m[k*32 +: 32] + cst, sh);
        return r;
    endfunction

    function automatic st_t model_r12(input logic [511:0] m, input st_t h);
        st_t s;
        s = h;
        for (int i = 0; i < 16; i++) s = md4_step(s, 1, i, m);
        for (int i = 0; i < 16; i++) s = md4_step(s, 2, i, m);
        return s;
    endfunction

    function automatic st_t model_r3(input st_t s_in, input logic [511:0] m, input st_t h, input bit ff);
        st_t s;
        s = s_in;
        for (int i = 0; i < 16; i++) s = md4_step(s, 3, i, m);
        if (ff) for (int j = 0; j < 4; j++) s[j] = s[j] + h[j];
        return s;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_block(input vec_t v);
        st_t s2;
        s2 = model_r12(v.x, v.h);
        @(negedge clk);
        a = s2[0]; b = s2[1]; c = s2[2]; d = s2[3];
        x = v.x;
        ha = v.h[0]; hb = v.h[1]; hc = v.h[2]; hd = v.h[3];
        in_valid = 1'b1;
        check("in_ready_at_accept", 160'(in_ready), 160'(1'b1));
        exp_q.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        ha = $urandom; hb = $urandom; hc = $urandom; hd = $urandom;
        for (int w = 0; w < 16; w++) x[w*32 +: 32] = $urandom;
    endtask

    task automatic wait_out();
        int cyc, bad_ready;
        cyc = 0;
        bad_ready = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) bad_ready++;
            @(negedge clk);
            cyc++;
        end
        check("latency", 160'(cyc), 160'(16));
        check("in_ready_low_in_run", 160'(bad_ready), 160'(0));
    endtask

    task automatic check_out();
        st_t e;
        if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard_empty: got output %0h expected none", {out_a, out_b, out_c, out_d});
        end else begin
            e = exp_q.pop_front();
            check("result", 160'({out_a, out_b, out_c, out_d}), 160'(pack(e)));
        end
    endtask

    task automatic run_block(input vec_t v);
        drive_block(v);
        wait_out();
        check_out();
        @(negedge clk);
        check("post_handshake_idle", 160'({out_valid, in_ready}), 160'(2'b01));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        st_t e, s;
        int  stray;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; x = '0; ha = '0; hb = '0; hc = '0; hd = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b1;
        z_a = '0; z_b = '0; z_c = '0; z_d = '0; z_x = '0;
        z_ha = '0; z_hb = '0; z_hc = '0; z_hd = '0;

        for (int n = 0; n < 6; n++) begin
            vecs[n].x = '0;
            vecs[n].h = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
        end
        vecs[0].x[31:0] = 32'h00000080;
        vecs[0].exp     = {32'hc089c0e0, 32'hd7593cb7, 32'h31e96ad1, 32'he0cfd631};
        vecs[1].x[31:0] = 32'h80636261;
        vecs[1].x[14*32 +: 32] = 32'h00000018;
        vecs[1].exp     = {32'h9d72a67a, 32'he80ac15f, 32'h52d821af, 32'h7a0148a4};
        for (int n = 2; n < 6; n++) begin
            for (int w = 0; w < 16; w++) vecs[n].x[w*32 +: 32] = $urandom;
            if (n == 5) vecs[n].x = '1;
            for (int j = 0; j < 4; j++) vecs[n].h[j] = (n == 5) ? 32'hffffffff : $urandom;
            vecs[n].exp = model_r3(model_r12(vecs[n].x, vecs[n].h), vecs[n].x, vecs[n].h, 1'b1);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", 160'({out_valid, out_a, out_b, out_c, out_d}), 160'(0));
        check("reset_in_ready", 160'({in_ready, z_in_ready, z_out_valid}), 160'(3'b110));

        for (int n = 0; n < 6; n++) run_block(vecs[n]);

        // Backpressure: result must hold while a competing request is presented
        out_ready = 1'b0;
        drive_block(vecs[1]);
        wait_out();
        e = exp_q[0];
        check_out();
        s = model_r12(vecs[0].x, vecs[0].h);
        a = s[0]; b = s[1]; c = s[2]; d = s[3]; x = vecs[0].x;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("bp_hold", 160'({out_valid, in_ready, out_a, out_b, out_c, out_d}),
                  160'({2'b10, pack(e)}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 160'({out_valid, in_ready, out_a, out_b, out_c, out_d}),
              160'({2'b01, pack(e)}));
        stray = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid || !in_ready) stray++;
        end
        check("bp_single_transfer", 160'(stray), 160'(0));

        // Reset while step 7 is pending discards the block
        drive_block(vecs[2]);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_reset", 160'({out_valid, in_ready, out_a, out_b, out_c, out_d}),
              160'({2'b01, 128'h0}));
        void'(exp_q.pop_front());
        run_block(vecs[1]);

        // Raw round-3 (no feed-forward), all-zero inputs, step by step
        @(negedge clk);
        z_in_valid = 1'b1;
        check("z_in_ready", 160'(z_in_ready), 160'(1'b1));
        @(posedge clk);
        @(negedge clk);
        z_in_valid = 1'b0;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s = md4_step(s, 3, i, 512'h0);
            if (i == 0) check("z_step0_a", 160'(dut0.r_a), 160'(32'h76CF5D0B));
            check($sformatf("z_step%0d", i), 160'({dut0.r_a, dut0.r_b, dut0.r_c, dut0.r_d}), 160'(pack(s)));
        end
        check("z_result", 160'({z_out_valid, z_out_a, z_out_b, z_out_c, z_out_d}),
              160'({1'b1, pack(s)}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
